// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch/data requests onto one RAM port (data first), with timeout/error trap.
// Optional one-entry instruction buffer enabled by defining MEM_ARB_IBUF_EN.  Rev 1.0
`default_nettype none

module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        ihit,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam logic [1:0]       RAM_ACCESS = 2'd2;
  localparam logic [1:0]       RAM_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t           state;
  logic [29:0]      word_q;
  logic [31:0]      data_q;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;

`ifdef MEM_ARB_IBUF_EN
  logic        ib_valid;
  logic [31:0] ib_tag;
  logic [31:0] ib_data;
  logic [1:0]  lo_q;
`endif

  // Byte-offset bits never reach the word-aligned RAM address.
  logic unused_lo;
  assign unused_lo = ^{daddr[1:0], iaddr[1:0]};

  // Enables follow state directly so an asynchronous reset drops them at once.
  assign ramREN   = (state == IACC) || (state == DACC && !wr_q);
  assign ramWEN   = (state == DACC) && wr_q;
  assign ramaddr  = (state == IACC || state == DACC) ? {word_q, 2'b00} : 32'd0;
  assign ramstore = ramWEN ? data_q : 32'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      word_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      cnt      <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      mem_err  <= 1'b0;
`ifdef MEM_ARB_IBUF_EN
      ib_valid <= 1'b0;
      ib_tag   <= '0;
      ib_data  <= '0;
      lo_q     <= '0;
`endif
    end else begin
      ihit  <= 1'b0;
      dhit  <= 1'b0;
      iload <= '0;
      dload <= '0;
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            word_q <= daddr[31:2];
            data_q <= dstore;
            wr_q   <= dWEN;
            cnt    <= '0;
            state  <= DACC;
          end else if (iREN) begin
`ifdef MEM_ARB_IBUF_EN
            if (ib_valid && iaddr == ib_tag) begin
              ihit  <= 1'b1;
              iload <= ib_data;
              state <= RESP;
            end else
`endif
            begin
              word_q <= iaddr[31:2];
`ifdef MEM_ARB_IBUF_EN
              lo_q   <= iaddr[1:0];
`endif
              cnt    <= '0;
              state  <= IACC;
            end
          end
        end
        DACC, IACC: begin
          if (ramstate == RAM_ACCESS) begin
            state <= RESP;
            if (state == IACC) begin
              ihit  <= 1'b1;
              iload <= ramload;
`ifdef MEM_ARB_IBUF_EN
              ib_valid <= 1'b1;
              ib_tag   <= {word_q, lo_q};
              ib_data  <= ramload;
`endif
            end else begin
              dhit  <= 1'b1;
              dload <= wr_q ? 32'd0 : ramload;
`ifdef MEM_ARB_IBUF_EN
              if (wr_q && word_q == ib_tag[31:2])
                ib_valid <= 1'b0;
`endif
            end
          end else if (ramstate == RAM_ERROR || cnt == CNT_LAST) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + randomized checks of mem_arbiter against a word-memory and latency model.
`default_nettype none

module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int npass  = 0;
  int ntotal = 0;

`ifdef MEM_ARB_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  // Reference state: memory contents by word and what the fetch buffer should hold.
  logic [31:0] mem [logic [29:0]];
  bit          ib_v = 1'b0;
  logic [31:0] ib_t = '0;

  mem_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Data access starting in an IDLE cycle; returns in the IDLE cycle after the hit.
  task automatic do_data(input bit ren, input bit wen, input logic [31:0] a,
                         input logic [31:0] d, input int busy);
    logic [31:0] exp_ld;
    dREN = ren; dWEN = wen; daddr = a; dstore = d; ramstate = FREE;
    chk("idle_ramREN", ramREN, 1'b0);
    step();
    for (int k = 0; k < busy; k++) begin
      chk("d_busy_REN", ramREN, !wen);
      chk("d_busy_WEN", ramWEN, wen);
      chk("d_busy_addr", ramaddr, {a[31:2], 2'b00});
      chk("d_busy_dhit", dhit, 1'b0);
      ramstate = BUSY; ramload = $urandom;
      step();
    end
    chk("d_acc_REN", ramREN, !wen);
    chk("d_acc_WEN", ramWEN, wen);
    chk("d_acc_addr", ramaddr, {a[31:2], 2'b00});
    chk("d_acc_store", ramstore, wen ? d : 32'd0);
    exp_ld = wen ? 32'd0 : rd(a);
    ramstate = ACCESS;
    ramload  = wen ? $urandom : rd(a);
    if (wen) begin
      mem[a[31:2]] = d;
      if (ib_v && ib_t[31:2] == a[31:2]) ib_v = 1'b0;
    end
    step();
    ramstate = FREE; ramload = $urandom;
    chk("dhit", dhit, 1'b1);
    chk("dload", dload, exp_ld);
    chk("d_resp_ihit", ihit, 1'b0);
    chk("d_resp_REN", ramREN | ramWEN, 1'b0);
    dREN = 1'b0; dWEN = 1'b0;
    step();
    chk("d_after_dhit", dhit, 1'b0);
  endtask

  // Fetch starting in an IDLE cycle; returns in the IDLE cycle after the hit.
  task automatic do_fetch(input logic [31:0] a, input int busy);
    bit buf_hit;
    buf_hit = IBUF && ib_v && ib_t == a;
    iREN = 1'b1; iaddr = a; ramstate = FREE;
    step();
    if (buf_hit) begin
      chk("ibuf_ihit", ihit, 1'b1);
      chk("ibuf_iload", iload, rd(a));
      chk("ibuf_noREN", ramREN, 1'b0);
    end else begin
      for (int k = 0; k < busy; k++) begin
        chk("i_busy_REN", ramREN, 1'b1);
        chk("i_busy_addr", ramaddr, a);
        chk("i_busy_ihit", ihit, 1'b0);
        ramstate = BUSY; ramload = $urandom;
        step();
      end
      chk("i_acc_REN", ramREN, 1'b1);
      chk("i_acc_WEN", ramWEN, 1'b0);
      chk("i_acc_addr", ramaddr, a);
      ramstate = ACCESS; ramload = rd(a);
      step();
      ramstate = FREE; ramload = $urandom;
      chk("ihit", ihit, 1'b1);
      chk("iload", iload, rd(a));
      ib_v = 1'b1; ib_t = a;
    end
    chk("i_resp_dhit", dhit, 1'b0);
    iREN = 1'b0;
    step();
    chk("i_after_ihit", ihit, 1'b0);
  endtask

  initial begin
    logic [31:0] fa;
    int          kind;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    mem[30'h1]      = 32'h8C220000;
    mem[30'h40]     = 32'h0000BEEF;
    step(); step();
    chk("rst_ihit", ihit, 1'b0);
    chk("rst_dhit", dhit, 1'b0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_mem_err", mem_err, 1'b0);
    RST = 1'b0;
    step();

    do_fetch(32'h4, 0);
    // Simultaneous requests: data first, then the held fetch from the following IDLE.
    iREN = 1'b1; iaddr = 32'h8;
    do_data(1'b1, 1'b0, 32'h100, 32'h0, 0);
    do_fetch(32'h8, 1);
    do_data(1'b0, 1'b1, 32'h203, 32'hDEADBEEF, 2);

    do_fetch(32'h40, 0);
    do_fetch(32'h40, 0);
    do_data(1'b0, 1'b1, 32'h40, 32'h12345678, 0);
    do_fetch(32'h40, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      fa   = 32'h1000 + 4 * $urandom_range(0, 5);
      case (kind)
        0: do_fetch(fa, $urandom_range(0, 3));
        1: do_data(1'b1, 1'b0, 32'h1000 + $urandom_range(0, 23), 32'h0, $urandom_range(0, 3));
        2: do_data($urandom_range(0, 1) == 1, 1'b1, 32'h1000 + $urandom_range(0, 23),
                   $urandom, $urandom_range(0, 3));
        default: begin
          iREN = 1'b1; iaddr = fa;
          do_data($urandom_range(0, 1) == 1, 1'b1, 32'h1000 + $urandom_range(0, 23),
                  $urandom, $urandom_range(0, 2));
          do_fetch(fa, $urandom_range(0, 2));
        end
      endcase
    end

    // Reset in the middle of a data access.
    dREN = 1'b1; daddr = 32'h500;
    step();
    chk("pre_rst_REN", ramREN, 1'b1);
    RST = 1'b1;
    #1;
    chk("async_rst_REN", ramREN, 1'b0);
    chk("async_rst_addr", ramaddr, 32'd0);
    chk("async_rst_dhit", dhit, 1'b0);
    RST = 1'b0; dREN = 1'b0; ib_v = 1'b0;
    ramstate = ACCESS;
    step();
    chk("post_rst_dhit", dhit, 1'b0);
    ramstate = FREE;
    do_data(1'b1, 1'b0, 32'h500, 32'h0, 1);

    // RAM held busy until the timeout trips.
    dREN = 1'b1; daddr = 32'h300;
    step();
    for (int k = 0; k < 15; k++) begin
      chk("to_REN", ramREN, 1'b1);
      chk("to_mem_err", mem_err, 1'b0);
      ramstate = BUSY;
      step();
    end
    chk("to_err", mem_err, 1'b1);
    chk("to_err_REN", ramREN | ramWEN, 1'b0);
    chk("to_err_addr", ramaddr, 32'd0);
    iREN = 1'b1; iaddr = 32'h4; ramstate = ACCESS;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("err_sticky", mem_err, 1'b1);
      chk("err_no_hit", ihit | dhit, 1'b0);
      chk("err_no_en", ramREN | ramWEN, 1'b0);
    end
    RST = 1'b1;
    #1;
    chk("err_cleared", mem_err, 1'b0);
    RST = 1'b0; iREN = 1'b0; dREN = 1'b0; ramstate = FREE; ib_v = 1'b0;
    step();

    // RAM reporting ERROR goes straight to the error state.
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFEF00D;
    step();
    chk("rerr_WEN", ramWEN, 1'b1);
    ramstate = ERROR;
    step();
    chk("rerr_mem_err", mem_err, 1'b1);
    chk("rerr_no_hit", dhit, 1'b0);
    RST = 1'b1;
    #1;
    RST = 1'b0; dWEN = 1'b0; ramstate = FREE; ib_v = 1'b0;
    step();
    do_fetch(32'h4, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
